// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_CORR   = 4'd3;

    // Smallest binary width able to hold 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint unsigned pow10;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        return $clog2(pow10);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake bundle between the requester and bcd2bin_seq.
interface bcd2bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) ();

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd2bin_seq_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: subtract 3 when >= 8.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_CORR) : digit_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, fixed BIN_W-cycle latency).
// Optional invalid-digit rejection is enabled with the BCD2BIN_CHECK_EN macro.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic          sys_clk,
    input  logic          reset,
    bcd2bin_seq_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
        $error("bcd2bin_seq: BIN_W too small for DIGITS");
    end

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               done_q, done_d;
    logic               abort;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_adj;

    assign shifted = {bcd_q, bin_q} >> 1;

    // Each digit is corrected after the shift, independently of its neighbours.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (shifted[BIN_W + 4*gi +: 4]),
            .digit_o (bcd_adj[4*gi +: 4])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic               err_q, err_d;
    logic [DIGITS-1:0]  digit_bad;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign digit_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
    end

    // A rejected request spends a single SHIFT cycle that only raises done.
    assign abort   = err_q;
    assign bus.err = err_q;
`else
    assign abort   = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        done_d    = 1'b0;
`ifdef BCD2BIN_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcd_d   = bus.bcd_in;
                    bin_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef BCD2BIN_CHECK_EN
                    err_d   = |digit_bad;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    bcd_d = bcd_adj;
                    bin_d = shifted[BIN_W-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bin_out_d = shifted[BIN_W-1:0];
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            done_q    <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
`ifdef BCD2BIN_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq; one line per comparison.
module tb_bcd2bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .sys_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("[TB] ok   %s: %0d (0x%0h)", tag, got, got);
        end
    endtask

    // Present a request for one edge; returns at the negedge after the accepting edge.
    task automatic start_conv(input logic [15:0] v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = v;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // lat = number of edges after the accepting edge until done is visible.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [15:0] v, input int exp_lat,
                            input bit chk_bin, input logic [13:0] exp_bin, input logic exp_err);
        int lat, bc;
        start_conv(v);
        wait_done(lat, bc);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, bc, exp_lat);
        if (chk_bin) check({tag, " bin_out"}, {18'd0, bus.bin_out}, {18'd0, exp_bin});
        check({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat, bc, gap, extra;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset bin_out", {18'd0, bus.bin_out}, 32'd0);
        check("reset err", {31'd0, bus.err}, 32'd0);
        rst = 1'b0;

        run_conv("zero", 16'h0000, 14, 1'b1, 14'd0, 1'b0);

        // Back-to-back with start held high; bcd_in change after acceptance must not matter.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h1234;
        @(negedge clk);
        bus.bcd_in = 16'h0081;
        wait_done(lat, bc);
        check("b2b 1234 latency", lat, 14);
        check("b2b 1234 busy cycles", bc, 14);
        check("b2b 1234 bin_out", {18'd0, bus.bin_out}, 32'd1234);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) begin
                bus.start = 1'b0;
                check("b2b reaccept busy", {31'd0, bus.busy}, 32'd1);
            end
        end while (bus.done !== 1'b1 && gap < 40);
        check("b2b done gap", gap, 15);
        check("b2b 0081 bin_out", {18'd0, bus.bin_out}, 32'd81);

        // Start pulse during a conversion is ignored.
        start_conv(16'h9999);
        repeat (5) @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h1111;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(lat, bc);
        check("9999 latency", lat + 6, 14);
        check("9999 bin_out", {18'd0, bus.bin_out}, 32'h270F);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        check("9999 single done", extra, 0);

        // Reset in the middle of a conversion.
        start_conv(16'h5555);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst bin_out", {18'd0, bus.bin_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        check("midrst no done", extra, 0);
        run_conv("post-rst 0567", 16'h0567, 14, 1'b1, 14'd567, 1'b0);

`ifdef BCD2BIN_CHECK_EN
        run_conv("bad 12A4", 16'h12A4, 1, 1'b1, 14'd567, 1'b1);
        run_conv("after-bad 0042", 16'h0042, 14, 1'b1, 14'd42, 1'b0);
`else
        run_conv("nochk 12A4", 16'h12A4, 14, 1'b0, 14'd0, 1'b0);
        run_conv("after 0042", 16'h0042, 14, 1'b1, 14'd42, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
